// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared constants for the CPU bus target (widths, MMIO map, STATUS bits).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_bus_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   // I/O window occupies the top eight addresses; base must stay 8-aligned
   // because the decode uses addr[2:0] directly as the register offset.
   localparam logic [ADDR_W-1:0] MMIO_BASE = 8'hF8;

   localparam logic [2:0] OFS_OUT0   = 3'd0;
   localparam logic [2:0] OFS_OUT1   = 3'd1;
   localparam logic [2:0] OFS_IN0    = 3'd2;
   localparam logic [2:0] OFS_IN1    = 3'd3;
   localparam logic [2:0] OFS_TMR_LO = 3'd4;
   localparam logic [2:0] OFS_TMR_HI = 3'd5;
   localparam logic [2:0] OFS_STATUS = 3'd6;

   localparam int ST_IN0_CHG  = 0;
   localparam int ST_TMR_WRAP = 1;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   function automatic logic is_mmio(input logic [ADDR_W-1:0] a);
      return a >= MMIO_BASE;
   endfunction

endpackage

// File: rtl/bus_timer16.sv
// bus_timer16: clk divider feeding a 16-bit free-running timer, with wrap pulse and high-byte snapshot.
// Latency: timer/hi_snap update on the edge of the tick/snap; wrap_o is a same-cycle pulse.
// Backpressure: none; always counting.
module bus_timer16 #(
   parameter int TIMER_DIV = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       snap_i,
   output logic [7:0] timer_lo_o,
   output logic [7:0] hi_snap_o,
   output logic       wrap_o
);

   localparam int DIV_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TIMER_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [15:0]      timer_q, timer_d;
   logic [7:0]       hi_snap_q, hi_snap_d;
   logic             tick;

   // Next state: divider rolls on terminal count and advances the timer;
   // the snapshot takes the pre-edge high byte so it pairs with the low byte read on the same edge.
   always_comb begin
      tick      = (div_q == DIV_LAST);
      div_d     = tick ? '0 : div_q + 1'b1;
      timer_d   = tick ? timer_q + 16'd1 : timer_q;
      hi_snap_d = snap_i ? timer_q[15:8] : hi_snap_q;
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q     <= '0;
         timer_q   <= '0;
         hi_snap_q <= '0;
      end else begin
         div_q     <= div_d;
         timer_q   <= timer_d;
         hi_snap_q <= hi_snap_d;
      end
   end

   assign timer_lo_o = timer_q[7:0];
   assign hi_snap_o  = hi_snap_q;
   assign wrap_o     = tick && (timer_q == 16'hFFFF);

endmodule

// File: rtl/cpu_bus_target.sv
// cpu_bus_target: CPU bus responder, 256x8 RAM at 00..F7 plus MMIO window F8..FF (latches, inputs, timer, status).
// Latency: rdata is registered and reflects the address sampled one edge earlier; holds until the next access.
// Backpressure: none; busy=1 only during the post-reset clear (macro CPU_BUS_TARGET_MEM_CLEAR_EN), accesses ignored.
module cpu_bus_target
   import cpu_bus_pkg::*;
#(
   parameter int TIMER_DIV = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   input  logic [DATA_W-1:0] in0,
   input  logic [DATA_W-1:0] in1,
   output logic [DATA_W-1:0] out0,
   output logic [DATA_W-1:0] out1
);

   logic [DATA_W-1:0] mem [0:255];

   logic [DATA_W-1:0] rdata_q, rdata_d, rd_val;
   logic [DATA_W-1:0] out0_q, out0_d, out1_q, out1_d;
   logic [DATA_W-1:0] in0_s1_q, in0_s2_q, in0_prev_q, in1_s1_q, in1_s2_q;
   logic [1:0]        sticky_q, sticky_d;
   logic [7:0]        timer_lo, hi_snap;
   logic              tmr_wrap, snap, st_clr, ram_we, is_io;
   logic [2:0]        ofs;
   logic              busy_w, mem_we;
   logic [ADDR_W-1:0] clr_addr, mem_wa;
   logic [DATA_W-1:0] mem_wd;

   assign is_io = is_mmio(addr);
   assign ofs   = addr[2:0];

   bus_timer16 #(.TIMER_DIV(TIMER_DIV)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .snap_i     (snap),
      .timer_lo_o (timer_lo),
      .hi_snap_o  (hi_snap),
      .wrap_o     (tmr_wrap)
   );

`ifdef CPU_BUS_TARGET_MEM_CLEAR_EN
   clr_state_t        clr_state_q, clr_state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

   // Clear sequencer next state: one address per cycle, leave after address 255.
   always_comb begin
      clr_state_d = clr_state_q;
      clr_addr_d  = clr_addr_q;
      if (clr_state_q == CLEAR) begin
         clr_addr_d = clr_addr_q + 1'b1;
         if (clr_addr_q == 8'hFF) clr_state_d = IDLE;
      end
   end

   // Clear sequencer state; reset (even mid-clear) restarts from address 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         clr_state_q <= CLEAR;
         clr_addr_q  <= '0;
      end else begin
         clr_state_q <= clr_state_d;
         clr_addr_q  <= clr_addr_d;
      end
   end

   assign busy_w   = (clr_state_q == CLEAR);
   assign clr_addr = clr_addr_q;
`else
   assign busy_w   = 1'b0;
   assign clr_addr = '0;
`endif

   // Decode: read mux, latch writes, and read side effects (a write cycle is not a read).
   always_comb begin
      rd_val = '0;
      out0_d = out0_q;
      out1_d = out1_q;
      snap   = 1'b0;
      st_clr = 1'b0;
      ram_we = 1'b0;
      if (!is_io) begin
         rd_val = mem[addr];
      end else begin
         case (ofs)
            OFS_OUT0:   rd_val = out0_q;
            OFS_OUT1:   rd_val = out1_q;
            OFS_IN0:    rd_val = in0_s2_q;
            OFS_IN1:    rd_val = in1_s2_q;
            OFS_TMR_LO: rd_val = timer_lo;
            OFS_TMR_HI: rd_val = hi_snap;
            OFS_STATUS: rd_val = {{(DATA_W-2){1'b0}}, sticky_q};
            default:    rd_val = '0;
         endcase
      end
      if (!busy_w) begin
         if (wr_en) begin
            if (!is_io)              ram_we = 1'b1;
            else if (ofs == OFS_OUT0) out0_d = wdata;
            else if (ofs == OFS_OUT1) out1_d = wdata;
         end else if (is_io) begin
            snap   = (ofs == OFS_TMR_LO);
            st_clr = (ofs == OFS_STATUS);
         end
      end
      rdata_d = busy_w ? '0 : rd_val;
      // Clear first, then set, so an event on the clearing edge survives.
      sticky_d = st_clr ? 2'b00 : sticky_q;
      if (in0_s2_q != in0_prev_q) sticky_d[ST_IN0_CHG]  = 1'b1;
      if (tmr_wrap)               sticky_d[ST_TMR_WRAP] = 1'b1;
   end

   // Bus-visible registers, synchronisers and sticky status.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q    <= '0;
         out0_q     <= '0;
         out1_q     <= '0;
         in0_s1_q   <= '0;
         in0_s2_q   <= '0;
         in0_prev_q <= '0;
         in1_s1_q   <= '0;
         in1_s2_q   <= '0;
         sticky_q   <= '0;
      end else begin
         rdata_q    <= rdata_d;
         out0_q     <= out0_d;
         out1_q     <= out1_d;
         in0_s1_q   <= in0;
         in0_s2_q   <= in0_s1_q;
         in0_prev_q <= in0_s2_q;
         in1_s1_q   <= in1;
         in1_s2_q   <= in1_s1_q;
         sticky_q   <= sticky_d;
      end
   end

   assign mem_we = busy_w | ram_we;
   assign mem_wa = busy_w ? clr_addr : addr;
   assign mem_wd = busy_w ? '0 : wdata;

   // RAM write port; no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

   assign rdata = rdata_q;
   assign busy  = busy_w;
   assign out0  = out0_q;
   assign out1  = out1_q;

endmodule

// File: doc/cpu_bus_target.md
Name: cpu_bus_target

Overview:
- Target (responder) end of the CPU memory bus: 8-bit address, write strobe, write data in, read data out.
- Combines a 256x8 synchronous RAM with a memory-mapped I/O window: output latches, synchronised input ports, and a 16-bit free-running timer with atomic read.
- Sits between the CPU core and the board pins (LED latches, switches); CPU wait-state timing relies on the fixed 1-cycle read latency defined here.

Parameters:
- ADDR_W, 8, address width; fixed at 8 for this CPU.
- DATA_W, 8, data width.
- MMIO_BASE, 8'hF8, first address of the 8-byte I/O window (F8..FF); RAM occupies 00..F7.
- TIMER_DIV, 12, clk cycles per timer tick (1 us at 12 MHz); must be >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  8  bus address, sampled every cycle.
- wr_en  in  1  write strobe, sampled with addr/wdata.
- wdata  in  8  write data.
- rdata  out  8  registered read data.
- busy  out  1  high while the bus ignores accesses (clear sequence only).
- in0  in  8  asynchronous input port 0.
- in1  in  8  asynchronous input port 1.
- out0  out  8  output latch 0.
- out1  out  8  output latch 1.

Behaviour:
- Reset values: rdata=0, out0=0, out1=0, timer=0, div counter=0, hi_snap=0, sticky=0, both sync stages=0. busy=1 with MEM_CLEAR_EN, otherwise 0.
- Read latency is exactly 1 cycle. rdata at edge N+1 reflects the addr sampled at edge N, and rdata holds between accesses.
- RAM write: at an edge with wr_en=1 and addr<MMIO_BASE, mem[addr]<=wdata.
- Read-during-write to the same address returns the old data.
- MMIO map, as offsets from MMIO_BASE:
  - +0 OUT0: R/W.
  - +1 OUT1: R/W.
  - +2 IN0: RO, 2-flop synchronised in0.
  - +3 IN1: RO, 2-flop synchronised in1.
  - +4 TIMER_LO: RO. Reading it captures timer[15:8] into hi_snap in the same edge.
  - +5 TIMER_HI: RO, returns hi_snap.
  - +6 STATUS: RO. bit0 = IN0 changed since last STATUS read (sticky), bit1 = timer wrapped since last STATUS read (sticky), bits[7:2]=0.
  - +7: reads 0, writes ignored.
- Writes to RO registers are ignored. MMIO writes never touch the RAM array.
- STATUS read returns the current sticky bits and clears them on that edge. If a set event occurs on the same edge, set wins and the bit remains 1.
- Timer:
  - Div counter counts 0..TIMER_DIV-1; on terminal count, timer increments.
  - timer 16'hFFFF -> 0 wraps and sets sticky bit1.
  - Timer runs during busy.
- IN0 change detect compares sync stage 2 with its previous value. Any difference sets sticky bit0.
- Out-of-window behaviour is a plain RAM access: addr F7 is RAM, F8 is OUT0.

Optional Feature:
- Macro: CPU_BUS_TARGET_MEM_CLEAR_EN.
- Defined:
  - After reset, a clear sequencer (states IDLE, CLEAR) writes 0 to mem[0..255] at one address per cycle. That is 256 cycles, with busy=1 throughout.
  - During CLEAR, bus reads return rdata=0 and bus writes are dropped. MMIO out0/out1 are not writable, and STATUS reads do not clear sticky bits.
  - busy falls on the edge after address 255 is written.
  - rst asserted mid-clear restarts at address 0.
- Undefined: no sequencer, busy tied 0, RAM contents after reset are unspecified (initial-file contents on FPGA).

Decomposition:
- Shared package/header (cpu_bus_pkg): ADDR_W, DATA_W, MMIO_BASE, MMIO register offsets (OFS_OUT0..OFS_STATUS), STATUS bit indices.
- One natural sub-module: bus_timer16 (divider, 16-bit counter, wrap pulse, hi_snap capture).
- RAM array, MMIO decode, synchronisers and clear sequencer stay in the top.

Test Plan:
- Write 8'h5A to 8'h10, then read 8'h10 -> rdata=8'h5A exactly one edge after the read address; a same-cycle write of 8'hA5 to 8'h10 with a read of 8'h10 returns 8'h5A, and the next read returns 8'hA5.
- Write 8'h3C to 8'hF8 and 8'hC3 to 8'hF9 -> out0=8'h3C, out1=8'hC3; read 8'hF8 -> 8'h3C; RAM location F8 is unaffected, and a write to 8'hFA does not change IN0 reads.
- Drive in0=8'h81 -> reading 8'hFA returns 8'h81 no earlier than 2 edges later; read STATUS -> 8'h01; read again -> 8'h00.
- Force timer to 16'h12FF, read TIMER_LO at the tick edge -> subsequent TIMER_HI read returns the captured 8'h12 or 8'h13 consistent with the LO value (never a torn pair); with timer 16'hFFFF -> wrap -> STATUS bit1=1.
- MEM_CLEAR_EN: preload mem[8'h20]=8'h77, pulse rst -> busy=1 for 256 cycles, a read during busy returns 0, and after busy falls a read of 8'h20 returns 8'h00.
- MEM_CLEAR_EN: assert rst at clear address 100 -> busy remains 1 for a further full 256 cycles; without the macro, busy=0 from the first edge after reset.
